sysbus_mem_responder: RTL and testbench

SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

---
 rtl/sysbus_resp_pkg.sv | 21 ++
 rtl/sysbus_mem_responder_if.sv | 24 ++
 rtl/sysbus_resp_mem.sv | 21 ++
 rtl/sysbus_mem_responder.sv | 105 ++++++++++
 tb/tb_sysbus_mem_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sysbus_resp_pkg.sv
// Shared types and line geometry for the sysbus memory responder.
package sysbus_resp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_WDATA,
    S_RWAIT,
    S_RDATA
  } state_e;

  localparam int BEATS_PER_LINE = 8;
  localparam int BEAT_W         = 3;
  localparam int TAG_WR_BIT     = 12;
  localparam int LINE_OFS_W     = 6;

  function automatic logic [BEAT_W-1:0] beat_inc(input logic [BEAT_W-1:0] b);
    return b + 3'd1;
  endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
interface sysbus_mem_responder_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/sysbus_resp_mem.sv
// Single-port backing store: synchronous write, one-cycle registered read, no reset.
module sysbus_resp_mem #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sysbus_mem_responder.sv
// 8-beat line memory responder on the sysbus request/response protocol.
// Define SYSBUS_RESP_CRITICAL_WORD_FIRST_EN to start read bursts at address[5:3].
module sysbus_mem_responder
  import sysbus_resp_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 2
) (
  input logic             clk,
  input logic             reset,
  sysbus_mem_responder_if.slave bus
);
  localparam int WA_W   = $clog2(MEM_WORDS);
  localparam int LINE_W = WA_W - BEAT_W;
  localparam int CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e                    r_state, w_state_nxt;
  logic [LINE_W-1:0]         r_line;
  logic [BEAT_W-1:0]         r_start;
  logic [BEAT_W-1:0]         r_beat;
  logic [CNT_W-1:0]          r_cnt;
  logic [BUS_TAG_WIDTH-1:0]  r_tag;

  logic                      w_reqack, w_respcyc, w_rd_adv, w_mem_we;
  logic [BEAT_W-1:0]         w_ofs;
  logic [WA_W-1:0]           w_mem_addr;
  logic [BUS_DATA_WIDTH-1:0] w_mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_reqack    = 1'b0;
    w_respcyc   = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.bus_reqcyc) w_state_nxt = S_ACK;
      S_ACK: begin
        w_reqack    = 1'b1;
        w_state_nxt = r_tag[TAG_WR_BIT] ? S_WDATA : S_RWAIT;
      end
      S_WDATA: if (bus.bus_reqcyc && r_beat == BEAT_W'(BEATS_PER_LINE - 1)) w_state_nxt = S_IDLE;
      S_RWAIT: if (r_cnt == '0) w_state_nxt = S_RDATA;
      S_RDATA: begin
        w_respcyc = 1'b1;
        if (bus.bus_respack && r_beat == BEAT_W'(BEATS_PER_LINE - 1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line  <= '0;
      r_start <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.bus_reqcyc) begin
          r_line  <= bus.bus_req[WA_W+2:LINE_OFS_W];
          r_tag   <= bus.bus_reqtag;
          r_beat  <= '0;
`ifdef SYSBUS_RESP_CRITICAL_WORD_FIRST_EN
          r_start <= bus.bus_req[5:3];
`else
          r_start <= '0;
`endif
        end
        S_ACK:   r_cnt <= CNT_W'(READ_LATENCY - 1);
        S_WDATA: if (bus.bus_reqcyc) r_beat <= beat_inc(r_beat);
        S_RWAIT: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        S_RDATA: if (bus.bus_respack) r_beat <= beat_inc(r_beat);
        default: ;
      endcase
    end
  end

  // Reads look one beat ahead on an ack so the next beat is ready the cycle after it.
  assign w_rd_adv   = (r_state == S_RDATA) && bus.bus_respack;
  assign w_ofs      = (r_state == S_WDATA) ? r_beat : (r_start + r_beat + BEAT_W'(w_rd_adv));
  assign w_mem_addr = {r_line, w_ofs};
  assign w_mem_we   = (r_state == S_WDATA) && bus.bus_reqcyc;

  sysbus_resp_mem #(
    .DATA_W (BUS_DATA_WIDTH),
    .ADDR_W (WA_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (bus.bus_req),
    .o_rdata (w_mem_rdata)
  );

  assign bus.bus_reqack  = w_reqack;
  assign bus.bus_respcyc = w_respcyc;
  assign bus.bus_resp    = w_respcyc ? w_mem_rdata : '0;
  assign bus.bus_resptag = w_respcyc ? r_tag : '0;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed table-driven bench for sysbus_mem_responder plus back-to-back and reset corner sequences.
module tb_sysbus_mem_responder;
  import sysbus_resp_pkg::*;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int MW = 4096;
  localparam int RL = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sysbus_mem_responder_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus ();

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (DW),
    .BUS_TAG_WIDTH  (TW),
    .MEM_WORDS      (MW),
    .READ_LATENCY   (RL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic             wr;
    logic [63:0]      addr;
    logic [12:0]      tag;
    logic [7:0]       gap;
    logic [2:0]       stall_beat;
    logic [3:0]       stall_n;
    logic [7:0][63:0] beats;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0][63:0] seq(input logic [63:0] first, input logic [63:0] step);
    logic [7:0][63:0] r;
    for (int i = 0; i < 8; i++) r[i] = first + step * 64'(i);
    return r;
  endfunction

  function automatic logic [7:0][63:0] rot(input logic [7:0][63:0] l, input int s);
    logic [7:0][63:0] r;
    for (int i = 0; i < 8; i++) r[i] = l[(i + s) % 8];
    return r;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [63:0] addr, input logic [12:0] tag,
                              input logic [7:0] gap, input logic [2:0] sb, input logic [3:0] sn,
                              input logic [7:0][63:0] beats);
    vec_t v;
    v.wr = wr; v.addr = addr; v.tag = tag; v.gap = gap;
    v.stall_beat = sb; v.stall_n = sn; v.beats = beats;
    return v;
  endfunction

  task automatic req_phase(input logic [63:0] addr, input logic [12:0] tag);
    chk("idle_reqack", 64'(bus.bus_reqack), 64'd0);
    bus.bus_reqcyc = 1'b1;
    bus.bus_req    = addr;
    bus.bus_reqtag = tag;
    tick();
    bus.bus_reqcyc = 1'b0;
    bus.bus_req    = '0;
    chk("reqack", 64'(bus.bus_reqack), 64'd1);
  endtask

  task automatic write_beats(input logic [7:0][63:0] d, input logic [7:0] gap, input int nbeats);
    tick();
    chk("reqack_one_cycle", 64'(bus.bus_reqack), 64'd0);
    for (int k = 0; k < nbeats; k++) begin
      if (gap[k]) begin
        bus.bus_reqcyc = 1'b0;
        bus.bus_req    = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        chk("wr_gap_no_resp", 64'(bus.bus_respcyc), 64'd0);
      end
      bus.bus_reqcyc = 1'b1;
      bus.bus_req    = d[k];
      tick();
      chk("wr_no_resp", 64'(bus.bus_respcyc), 64'd0);
    end
    bus.bus_reqcyc = 1'b0;
    bus.bus_req    = '0;
    if (nbeats == 8) chk("wr_back_idle", 64'(dut.r_state == S_IDLE), 64'd1);
  endtask

  task automatic read_beats(input logic [12:0] tag, input logic [7:0][63:0] exp,
                            input int sb, input int sn,
                            input bit bg, input logic [63:0] bg_addr, input logic [12:0] bg_tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.bus_respcyc && n < 20);
    chk("rd_latency", 64'(n), 64'(RL + 1));
    if (bg) begin
      bus.bus_reqcyc = 1'b1;
      bus.bus_req    = bg_addr;
      bus.bus_reqtag = bg_tag;
    end
    for (int b = 0; b < 8; b++) begin
      chk("rd_data", bus.bus_resp, exp[b]);
      chk("rd_tag", 64'(bus.bus_resptag), 64'(tag));
      if (bg) chk("no_ack_while_busy", 64'(bus.bus_reqack), 64'd0);
      if (b == sb) begin
        for (int s = 0; s < sn; s++) begin
          bus.bus_respack = 1'b0;
          tick();
          chk("stall_hold_data", bus.bus_resp, exp[b]);
          chk("stall_hold_cyc", 64'(bus.bus_respcyc), 64'd1);
        end
      end
      bus.bus_respack = 1'b1;
      tick();
      bus.bus_respack = 1'b0;
    end
    chk("rd_done_respcyc", 64'(bus.bus_respcyc), 64'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_reqack", 64'(bus.bus_reqack), 64'd0);
    chk("rst_respcyc", 64'(bus.bus_respcyc), 64'd0);
    chk("rst_resp", bus.bus_resp, 64'd0);
    chk("rst_resptag", 64'(bus.bus_resptag), 64'd0);
  endtask

  initial begin
    logic [7:0][63:0] l11, la, lb, lc, lmix, l1028;
    int n;
    bus.bus_reqcyc  = 1'b0;
    bus.bus_req     = '0;
    bus.bus_reqtag  = '0;
    bus.bus_respack = 1'b0;

    l11 = seq(64'h11, 64'h11);
    la  = seq(64'hA1, 64'h1);
    lb  = seq(64'hB0, 64'h1);
    lc  = seq(64'hC0, 64'h1);
`ifdef SYSBUS_RESP_CRITICAL_WORD_FIRST_EN
    l1028 = rot(l11, 5);
`else
    l1028 = l11;
`endif

    vecs[0] = mk(1'b1, 64'h1000, 13'h1001, 8'h00, 3'd0, 4'd0, l11);
    vecs[1] = mk(1'b0, 64'h1000, 13'h0042, 8'h00, 3'd0, 4'd0, l11);
    vecs[2] = mk(1'b0, 64'h1028, 13'h0043, 8'h00, 3'd0, 4'd0, l1028);
    vecs[3] = mk(1'b0, 64'h1000, 13'h0044, 8'h00, 3'd2, 4'd3, l11);
    vecs[4] = mk(1'b1, 64'h1000 + 64'(MW) * 64'd8, 13'h1005, 8'b1010_0110, 3'd0, 4'd0, la);
    vecs[5] = mk(1'b0, 64'h1000, 13'h0046, 8'h00, 3'd0, 4'd0, la);
    vecs[6] = mk(1'b1, 64'h2000, 13'h1FFF, 8'h00, 3'd0, 4'd0, lb);
    vecs[7] = mk(1'b0, 64'hFFFF_0000_0000_2007, 13'h0FFF, 8'h00, 3'd0, 4'd0, lb);
    vecs[8] = mk(1'b0, 64'h2000, 13'h0000, 8'h00, 3'd7, 4'd2, lb);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      req_phase(vecs[i].addr, vecs[i].tag);
      if (vecs[i].wr) write_beats(vecs[i].beats, vecs[i].gap, 8);
      else read_beats(vecs[i].tag, vecs[i].beats, int'(vecs[i].stall_beat),
                      int'(vecs[i].stall_n), 1'b0, 64'd0, 13'd0);
    end

    // Request held during a read burst is only taken once the burst finishes.
    req_phase(64'h1000, 13'h0050);
    read_beats(13'h0050, la, 0, 0, 1'b1, 64'h2000, 13'h0051);
    tick();
    chk("b2b_reqack", 64'(bus.bus_reqack), 64'd1);
    bus.bus_reqcyc = 1'b0;
    read_beats(13'h0051, lb, 0, 0, 1'b0, 64'd0, 13'd0);

    // Reset mid-write keeps the beats already stored.
    req_phase(64'h2000, 13'h1002);
    write_beats(lc, 8'h00, 3);
    #2 reset = 1'b0;
    #1 chk_reset_outputs();
    chk("rst_wr_idle", 64'(dut.r_state == S_IDLE), 64'd0 + 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    lmix = lb;
    lmix[0] = lc[0];
    lmix[1] = lc[1];
    lmix[2] = lc[2];
    req_phase(64'h2000, 13'h0070);
    read_beats(13'h0070, lmix, 0, 0, 1'b0, 64'd0, 13'd0);

    // Reset mid-read drops the burst immediately.
    req_phase(64'h1000, 13'h0060);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.bus_respcyc && n < 20);
    chk("rst_rd_latency", 64'(n), 64'(RL + 1));
    bus.bus_respack = 1'b1;
    tick();
    tick();
    bus.bus_respack = 1'b0;
    chk("pre_rst_respcyc", 64'(bus.bus_respcyc), 64'd1);
    chk("pre_rst_resp", bus.bus_resp, la[2]);
    #2 reset = 1'b0;
    #1 chk_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    req_phase(64'h1000, 13'h0061);
    read_beats(13'h0061, la, 0, 0, 1'b0, 64'd0, 13'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
